// File: rtl/regbank_pkg.sv
// Shared constants and FSM state type for the multi-port register bank.
// Optional forwarding is selected in regbank_mp by REGBANK_BYPASS_EN.
package regbank_pkg;

    localparam int DEF_WIDTH_ADDR_LENGTH = 5;
    localparam int DEF_WIDTH_DATA_LENGTH = 32;
    localparam int DEF_NUM_READ_PORTS    = 2;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } regbankState_e;

endpackage

// File: rtl/regbank_clear_ctrl.sv
// Power-up/reset clear sequencer: walks every entry writing zero, then
// raises ready and stays there until the next reset.
module regbank_clear_ctrl
    import regbank_pkg::*;
#(
    parameter int WIDTH_ADDR_LENGTH = DEF_WIDTH_ADDR_LENGTH
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         ready,
    output logic                         clearWEn,
    output logic [WIDTH_ADDR_LENGTH-1:0] clearIdx
);

    regbankState_e               state;
    logic [WIDTH_ADDR_LENGTH-1:0] cnt;

    // Reset from any state restarts the sweep at entry 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_CLEAR;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == '1) begin
                        state <= ST_READY;
                        ready <= 1'b1;
                    end
                end
                ST_READY: begin
                    ready <= 1'b1;
                end
                default: begin
                    state <= ST_CLEAR;
                    cnt   <= '0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    assign clearWEn = (state == ST_CLEAR) && !rst;
    assign clearIdx = cnt;

endmodule

// File: rtl/regbank_mp.sv
// Register bank with one write port, NUM_READ_PORTS combinational read ports
// and a pending-write scoreboard. Define REGBANK_BYPASS_EN for write forwarding.
module regbank_mp
    import regbank_pkg::*;
#(
    parameter int WIDTH_ADDR_LENGTH = DEF_WIDTH_ADDR_LENGTH,
    parameter int WIDTH_DATA_LENGTH = DEF_WIDTH_DATA_LENGTH,
    parameter int NUM_READ_PORTS    = DEF_NUM_READ_PORTS
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   RegWEn,
    input  logic [WIDTH_ADDR_LENGTH-1:0]           AddrD,
    input  logic [WIDTH_DATA_LENGTH-1:0]           DataD,
    input  logic [NUM_READ_PORTS*WIDTH_ADDR_LENGTH-1:0] AddrR,
    output logic [NUM_READ_PORTS*WIDTH_DATA_LENGTH-1:0] DataR,
    input  logic                                   BusySet,
    input  logic [WIDTH_ADDR_LENGTH-1:0]           BusyAddr,
    output logic [NUM_READ_PORTS-1:0]              Busy,
    output logic                                   Ready
);

    localparam int WA    = WIDTH_ADDR_LENGTH;
    localparam int WD    = WIDTH_DATA_LENGTH;
    localparam int DEPTH = 2 ** WA;

    logic          ready;
    logic          clearWEn;
    logic [WA-1:0] clearIdx;

    logic [WD-1:0]    regs [DEPTH];
    logic [DEPTH-1:0] busyBits;
    logic [DEPTH-1:0] busyNext;
    logic [WA-1:0]    readAddr [NUM_READ_PORTS];
    logic             writeHit;

    regbank_clear_ctrl #(
        .WIDTH_ADDR_LENGTH(WA)
    ) clearCtrl (
        .clk     (clk),
        .rst     (rst),
        .ready   (ready),
        .clearWEn(clearWEn),
        .clearIdx(clearIdx)
    );

    assign Ready    = ready;
    assign writeHit = ready && RegWEn && (AddrD != '0);

    // Storage has no reset; zeroing happens only through the clear sweep.
    always_ff @(posedge clk) begin
        if (clearWEn) begin
            regs[clearIdx] <= '0;
        end else if (writeHit && !rst) begin
            regs[AddrD] <= DataD;
        end
    end

    always_comb begin
        busyNext = busyBits;
        if (RegWEn) begin
            busyNext[AddrD] = 1'b0;
        end
        if (BusySet) begin
            busyNext[BusyAddr] = 1'b1;
        end
        busyNext[0] = 1'b0;
    end

    // Set beats clear when both hit the same index in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            busyBits <= '0;
        end else if (ready) begin
            busyBits <= busyNext;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_READ_PORTS; i++) begin
            readAddr[i] = AddrR[i*WA +: WA];
        end
    end

    always_comb begin
        DataR = '0;
        Busy  = '0;
        for (int i = 0; i < NUM_READ_PORTS; i++) begin
            if (ready && (readAddr[i] != '0)) begin
                DataR[i*WD +: WD] = regs[readAddr[i]];
                Busy[i]           = busyBits[readAddr[i]];
`ifdef REGBANK_BYPASS_EN
                if (writeHit && (readAddr[i] == AddrD)) begin
                    DataR[i*WD +: WD] = DataD;
                    Busy[i]           = BusySet && (BusyAddr == AddrD);
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_regbank_mp.sv
// Self-checking bench for regbank_mp: directed scenarios plus random traffic
// compared every cycle against an array-based model of the bank.
module tb_regbank_mp;

    localparam int WA    = 5;
    localparam int WD    = 32;
    localparam int NP    = 2;
    localparam int DEPTH = 32;

    logic              clk      = 1'b0;
    logic              rst      = 1'b1;
    logic              RegWEn   = 1'b0;
    logic [WA-1:0]     AddrD    = '0;
    logic [WD-1:0]     DataD    = '0;
    logic [NP*WA-1:0]  AddrR    = '0;
    logic [NP*WD-1:0]  DataR;
    logic              BusySet  = 1'b0;
    logic [WA-1:0]     BusyAddr = '0;
    logic [NP-1:0]     Busy;
    logic              Ready;

    int totalCount = 0;
    int passCount  = 0;

    regbank_mp #(
        .WIDTH_ADDR_LENGTH(WA),
        .WIDTH_DATA_LENGTH(WD),
        .NUM_READ_PORTS   (NP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .RegWEn  (RegWEn),
        .AddrD   (AddrD),
        .DataD   (DataD),
        .AddrR   (AddrR),
        .DataR   (DataR),
        .BusySet (BusySet),
        .BusyAddr(BusyAddr),
        .Busy    (Busy),
        .Ready   (Ready)
    );

    always #5 clk = ~clk;

    logic [WD-1:0]    mRegs [DEPTH];
    logic [DEPTH-1:0] mBusy      = '0;
    int               clearEdges = 0;
    bit               mReady     = 1'b0;
    bit               started    = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        totalCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [WA-1:0] ad, input logic [WD-1:0] dd,
                                 input logic [WA-1:0] r0, input logic [WA-1:0] r1,
                                 input logic bs, input logic [WA-1:0] ba);
        RegWEn   = we;
        AddrD    = ad;
        DataD    = dd;
        AddrR    = {r1, r0};
        BusySet  = bs;
        BusyAddr = ba;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic waitReady(output int edges);
        bit seen;
        seen  = 1'b0;
        edges = 0;
        for (int n = 1; n <= 40 && !seen; n++) begin
            stepCycle();
            edges = n;
            if (Ready === 1'b1) seen = 1'b1;
        end
        if (!seen) edges = 99;
    endtask

    // Model: the bank is all-zero once 32 reset-free edges have elapsed.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                started    = 1'b1;
                clearEdges = 0;
                mReady     = 1'b0;
                mBusy      = '0;
            end else if (started) begin
                if (!mReady) begin
                    clearEdges++;
                    if (clearEdges == DEPTH) begin
                        mReady = 1'b1;
                        for (int k = 0; k < DEPTH; k++) mRegs[k] = '0;
                    end
                end else begin
                    if (RegWEn && AddrD != 0) mRegs[AddrD] = DataD;
                    if (RegWEn) mBusy[AddrD] = 1'b0;
                    if (BusySet && BusyAddr != 0) mBusy[BusyAddr] = 1'b1;
                end
            end
        end
    end

    function automatic logic [WD-1:0] expData(input logic [WA-1:0] a);
        if (!mReady || a == 0) return '0;
`ifdef REGBANK_BYPASS_EN
        if (RegWEn && AddrD != 0 && a == AddrD) return DataD;
`endif
        return mRegs[a];
    endfunction

    function automatic logic expBusy(input logic [WA-1:0] a);
        if (!mReady) return 1'b0;
`ifdef REGBANK_BYPASS_EN
        if (RegWEn && AddrD != 0 && a == AddrD) return BusySet && (BusyAddr == a);
`endif
        return mBusy[a];
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                checkOutput("cmpReady", {63'd0, Ready}, {63'd0, mReady});
                for (int p = 0; p < NP; p++) begin
                    checkOutput($sformatf("cmpDataR%0d", p), {32'd0, DataR[p*WD +: WD]},
                                {32'd0, expData(AddrR[p*WA +: WA])});
                    checkOutput($sformatf("cmpBusy%0d", p), {63'd0, Busy[p]},
                                {63'd0, expBusy(AddrR[p*WA +: WA])});
                end
            end
        end
    end

    initial begin
        int edges;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        stepCycle();
        checkOutput("resetReady", {63'd0, Ready}, 64'd0);
        checkOutput("resetBusy", {62'd0, Busy}, 64'd0);
        checkOutput("resetDataR", DataR, 64'd0);
        stepCycle();
        rst = 1'b0;
        waitReady(edges);
        checkOutput("clearEdges", 64'(edges), 64'd32);

        for (int a = 0; a < DEPTH; a += 2) begin
            applyStimulus(0, 0, 0, WA'(a), WA'(a + 1), 0, 0);
            #2;
            checkOutput("clearedZero", DataR, 64'd0);
            stepCycle();
        end

        applyStimulus(1, 1, 32'hFFFF_AAAA, 1, 1, 0, 0);
        stepCycle();
        applyStimulus(0, 0, 0, 1, 1, 0, 0);
        #2;
        checkOutput("readX1Both", DataR, {2{32'hFFFF_AAAA}});
        stepCycle();
        applyStimulus(1, 0, 32'h1234_5678, 0, 0, 0, 0);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        #2;
        checkOutput("x0ReadsZero", {32'd0, DataR[31:0]}, 64'd0);
        stepCycle();

        applyStimulus(1, 5, 32'hDEAD_BEEF, 5, 0, 0, 0);
        #2;
`ifdef REGBANK_BYPASS_EN
        checkOutput("bypassRead", {32'd0, DataR[31:0]}, 64'hDEAD_BEEF);
`else
        checkOutput("bypassRead", {32'd0, DataR[31:0]}, 64'd0);
`endif
        stepCycle();
        applyStimulus(0, 0, 0, 5, 0, 0, 0);
        #2;
        checkOutput("x5AfterWrite", {32'd0, DataR[31:0]}, 64'hDEAD_BEEF);
        stepCycle();

        applyStimulus(0, 0, 0, 7, 0, 1, 7);
        stepCycle();
        applyStimulus(0, 0, 0, 7, 0, 0, 0);
        #2;
        checkOutput("busySetX7", {63'd0, Busy[0]}, 64'd1);
        stepCycle();
        applyStimulus(1, 7, 32'h77, 7, 0, 1, 7);
        stepCycle();
        applyStimulus(0, 0, 0, 7, 0, 0, 0);
        #2;
        checkOutput("setWinsX7", {63'd0, Busy[0]}, 64'd1);
        stepCycle();
        applyStimulus(1, 7, 32'h88, 7, 0, 0, 0);
        stepCycle();
        applyStimulus(0, 0, 0, 7, 0, 0, 0);
        #2;
        checkOutput("busyClearX7", {63'd0, Busy[0]}, 64'd0);
        stepCycle();

        rst = 1'b1;
        repeat (2) stepCycle();
        rst = 1'b0;
        repeat (10) stepCycle();
        rst = 1'b1;
        stepCycle();
        checkOutput("midClearReady", {63'd0, Ready}, 64'd0);
        rst = 1'b0;
        waitReady(edges);
        checkOutput("midClearRestart", 64'(edges), 64'd32);
        applyStimulus(0, 0, 0, 1, 7, 0, 0);
        #2;
        checkOutput("reclearedX1X7", DataR, 64'd0);
        stepCycle();

        applyStimulus(0, 0, 0, 3, 3, 1, 3);
        stepCycle();
        applyStimulus(0, 0, 0, 3, 3, 0, 0);
        #2;
        checkOutput("x3Busy", {62'd0, Busy}, 64'd3);
        stepCycle();
        rst = 1'b1;
        stepCycle();
        checkOutput("readyRstReady", {63'd0, Ready}, 64'd0);
        checkOutput("readyRstBusy", {62'd0, Busy}, 64'd0);
        rst = 1'b0;
        waitReady(edges);
        checkOutput("readyRstRestart", 64'(edges), 64'd32);
        #2;
        checkOutput("x3NotBusy", {62'd0, Busy}, 64'd0);

        for (int n = 0; n < 1500; n++) begin
            logic [WA-1:0] ad, r0, r1, ba;
            ad = ($urandom_range(0, 3) == 0) ? WA'($urandom_range(0, 31)) : WA'($urandom_range(0, 7));
            r0 = ($urandom_range(0, 3) == 0) ? WA'($urandom_range(0, 31)) : WA'($urandom_range(0, 7));
            r1 = ($urandom_range(0, 3) == 0) ? WA'($urandom_range(0, 31)) : WA'($urandom_range(0, 7));
            ba = ($urandom_range(0, 3) == 0) ? WA'($urandom_range(0, 31)) : WA'($urandom_range(0, 7));
            applyStimulus(1'($urandom_range(0, 1)), ad, $urandom, r0, r1,
                          1'($urandom_range(0, 3) == 0), ba);
            rst = ($urandom_range(0, 299) == 0);
            stepCycle();
        end
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        waitReady(edges);
        stepCycle();

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule

// File: doc/regbank_mp.md
REGBANK_MP -- requirements
Module: regbank_mp

Interface
REQ-001 SHALL have parameter WIDTH_ADDR_LENGTH, default 5, meaning register index width; depth DEPTH = 2**WIDTH_ADDR_LENGTH.
REQ-002 SHALL have parameter WIDTH_DATA_LENGTH, default 32, meaning register data width.
REQ-003 SHALL have parameter NUM_READ_PORTS, default 2, range 1..4, meaning independent read ports.
REQ-004 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1 bit, meaning reset, synchronous and active-high.
REQ-006 SHALL have port RegWEn, input, 1 bit, meaning write enable.
REQ-007 SHALL have port AddrD, input, WIDTH_ADDR_LENGTH bits, meaning write index.
REQ-008 SHALL have port DataD, input, WIDTH_DATA_LENGTH bits, meaning write data.
REQ-009 SHALL have port AddrR, input, NUM_READ_PORTS*WIDTH_ADDR_LENGTH bits, meaning packed read indices; port i at slice i.
REQ-010 SHALL have port DataR, output, NUM_READ_PORTS*WIDTH_DATA_LENGTH bits, meaning packed read data; port i at slice i.
REQ-011 SHALL have port BusySet, input, 1 bit, meaning mark BusyAddr as pending-write.
REQ-012 SHALL have port BusyAddr, input, WIDTH_ADDR_LENGTH bits, meaning index to mark busy.
REQ-013 SHALL have port Busy, output, NUM_READ_PORTS bits, meaning pending-write flag of AddrR[i].
REQ-014 SHALL have port Ready, output, 1 bit, meaning clear sequence complete; bank usable.

Function
REQ-015 SHALL implement FSM states ST_CLEAR and ST_READY, with a clear counter of WIDTH_ADDR_LENGTH bits.
REQ-016 In ST_CLEAR, each edge with rst low SHALL write zero to entry[cnt] and increment cnt; on the edge that clears entry DEPTH-1, the FSM SHALL enter ST_READY. Ready therefore rises at the DEPTH-th rising edge after rst deasserts.
REQ-017 In ST_CLEAR, the bank SHALL ignore RegWEn and BusySet, drive all DataR slices 0, and drive Busy all 0.
REQ-018 In ST_READY, RegWEn=1 with AddrD!=0 SHALL write DataD to entry[AddrD] at the edge.
REQ-019 Entry 0 SHALL always read 0; writes to it SHALL be dropped and it SHALL never be busy.
REQ-020 Reads SHALL be combinational (zero latency) from AddrR[i]; any number of ports MAY address the same entry.
REQ-021 Scoreboard: a BusySet edge SHALL set busy[BusyAddr]; a RegWEn edge SHALL clear busy[AddrD]. When set and clear target the same index in one cycle, set SHALL win.
REQ-022 Busy[i] SHALL equal busy[AddrR[i]] as registered, except as modified by REQ-027.

Reset
REQ-023 rst high at an edge SHALL force ST_CLEAR, cnt=0, Ready=0 and all busy bits to 0; this SHALL apply from any state, including mid-clear, which restarts at entry 0.
REQ-024 Entry contents SHALL NOT be cleared by rst directly; zeroing SHALL occur only through the clear sequence.
REQ-025 During and after reset, until Ready, outputs SHALL be DataR=0, Busy=0 and Ready=0.

Configuration
REQ-026 Macro REGBANK_BYPASS_EN SHALL select write-to-read forwarding.
REQ-027 With REGBANK_BYPASS_EN defined, in ST_READY with RegWEn=1, AddrD!=0 and AddrR[i]==AddrD, DataR[i] SHALL equal DataD. Busy[i] SHALL be 0 unless BusySet targets the same index in that cycle.
REQ-028 Without REGBANK_BYPASS_EN, DataR[i] SHALL return the stored value until the edge after the write, and Busy SHALL be purely registered.

Structure
REQ-029 Package regbank_pkg SHALL hold the default parameter constants and the FSM state typedef (ST_CLEAR, ST_READY).
REQ-030 The FSM and counter SHALL live in a sub-module regbank_clear_ctrl, which outputs Ready, clear-write enable and clear index. Storage, ports and scoreboard SHALL stay in regbank_mp.

Verification
REQ-031 Clear sequence: hold rst 2 cycles then release -> Ready=0 for 31 edges, Ready=1 after the 32nd edge; all 32 entries read 0.
REQ-032 Write/read: write 0xFFFF_AAAA to x1, then read AddrR={1,1} -> both ports return 0xFFFF_AAAA next cycle. Write 0x1234_5678 to x0 -> x0 reads 0.
REQ-033 Bypass: in the write cycle, AddrD=5, DataD=0xDEAD_BEEF, AddrR[0]=5 -> DataR[0]=0xDEAD_BEEF with REGBANK_BYPASS_EN; old value 0 without it.
REQ-034 Scoreboard: BusySet on x7 -> Busy=1 for AddrR=7. Simultaneous BusySet x7 and write x7 -> busy remains 1. Write x7 alone -> busy clears.
REQ-035 Reset mid-operation: assert rst at clear index 10 and again with x3 busy in ST_READY -> cnt restarts at 0, Ready=0, Busy=0, and the full 32-edge clear repeats.
